// File: rtl/pixel_load_sequencer.sv
// pixel_load_sequencer: repacks 16-bit FIFO words into 24-bit pixels and writes them to image memory
module pixel_load_sequencer #(
  parameter int N_PIXELS = 512,
  parameter int ADDR_W   = 9
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic [15:0]       fifo_dout,
  input  logic              fifo_lw,
  input  logic              fifo_hw,
  output logic              fifo_pop,
  output logic              sdram_pause,
  output logic              sdram_unpause,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pixel_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W+1)'(N_PIXELS - 1);
  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [15:0]         hold_hi_q, hold_hi_d;
  logic [7:0]          hold_lo_q, hold_lo_d;
  logic                last_q, last_d;
  logic [ADDR_W:0]     issued_q, issued_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [23:0]         din_q, din_d;
  logic                pause_q, pause_d;
  logic                unpause_q, unpause_d;
  logic                launch, final_wr, busy_next;
  // Next state, byte repacking, write staging and flow-control decisions
  always_comb begin
    launch    = start & (state_q != LOAD);
    final_wr  = we_q & ({1'b0, addr_q} == LAST_PIX);
    fifo_pop  = (state_q == LOAD) & !fifo_empty & !last_q;
    state_d   = launch ? LOAD : (state_q == LOAD && final_wr) ? DONE : state_q;
    busy_next = (state_d == LOAD);
    phase_d   = launch ? 2'd0 : fifo_pop ? ((phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1) : phase_q;
    hold_hi_d = (fifo_pop && phase_q == 2'd0) ? fifo_dout : hold_hi_q;
    hold_lo_d = (fifo_pop && phase_q == 2'd1) ? fifo_dout[7:0] : hold_lo_q;
    we_d      = fifo_pop & (phase_q != 2'd0);
    din_d     = !we_d ? din_q : (phase_q == 2'd1) ? {hold_hi_q, fifo_dout[15:8]} : {hold_lo_q, fifo_dout};
    issued_d  = launch ? '0 : issued_q + (ADDR_W+1)'(we_d);
    last_d    = launch ? 1'b0 : last_q | (we_d & (issued_q == LAST_PIX));
    addr_d    = launch ? '0 : addr_q + ADDR_W'(we_q);
    cnt_d     = launch ? '0 : cnt_q + (ADDR_W+1)'(we_q);
    pause_d   = !busy_next | fifo_hw;
    unpause_d = busy_next & fifo_lw & !fifo_hw;
  end
  // State and datapath registers; reset parks the SDRAM side paused
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      hold_hi_q <= '0;
      hold_lo_q <= '0;
      last_q    <= 1'b0;
      issued_q  <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      pause_q   <= 1'b1;
      unpause_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      hold_hi_q <= hold_hi_d;
      hold_lo_q <= hold_lo_d;
      last_q    <= last_d;
      issued_q  <= issued_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      pause_q   <= pause_d;
      unpause_q <= unpause_d;
    end
  end
  assign sdram_pause   = pause_q;
  assign sdram_unpause = unpause_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_din       = din_q;
  assign busy          = (state_q == LOAD);
  assign done          = (state_q == DONE);
  assign pixel_count   = cnt_q;
endmodule

// File: tb/tb_pixel_load_sequencer.sv
// tb_pixel_load_sequencer: scoreboard bench for N_PIXELS=4 and N_PIXELS=3 instances
module tb_pixel_load_sequencer;
  localparam int AW = 9;
  logic clk50 = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic hw = 1'b0, lw = 1'b0;
  logic gate [2] = '{1'b0, 1'b0};
  int rp [2];
  int wp [2];
  logic [15:0] fm [2][1024];
  logic empty [2], pop [2], pause [2], unpause [2], we [2], busy [2], done [2];
  logic [AW-1:0] addr [2];
  logic [23:0] din [2];
  logic [AW:0] cnt [2];
  logic [15:0] dout [2];
  logic [23:0] exd [2][1024];
  int exa [2][1024];
  int eh [2], et [2], rp_end [2];
  int errors = 0, checks = 0, mode = 0;
  bit mon_en = 1'b0;

  always #10 clk50 = ~clk50;

  assign empty[0] = (rp[0] == wp[0]) | gate[0];
  assign empty[1] = (rp[1] == wp[1]) | gate[1];
  assign dout[0]  = fm[0][rp[0][9:0]];
  assign dout[1]  = fm[1][rp[1][9:0]];

  pixel_load_sequencer #(.N_PIXELS(4), .ADDR_W(AW)) u4 (
    .clk50(clk50), .reset(reset), .start(start), .fifo_empty(empty[0]), .fifo_dout(dout[0]),
    .fifo_lw(lw), .fifo_hw(hw), .fifo_pop(pop[0]), .sdram_pause(pause[0]), .sdram_unpause(unpause[0]),
    .mem_we(we[0]), .mem_addr(addr[0]), .mem_din(din[0]), .busy(busy[0]), .done(done[0]),
    .pixel_count(cnt[0]));

  pixel_load_sequencer #(.N_PIXELS(3), .ADDR_W(AW)) u3 (
    .clk50(clk50), .reset(reset), .start(start), .fifo_empty(empty[1]), .fifo_dout(dout[1]),
    .fifo_lw(lw), .fifo_hw(hw), .fifo_pop(pop[1]), .sdram_pause(pause[1]), .sdram_unpause(unpause[1]),
    .mem_we(we[1]), .mem_addr(addr[1]), .mem_din(din[1]), .busy(busy[1]), .done(done[1]),
    .pixel_count(cnt[1]));

  function automatic int npix(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic chk(input int i, input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", i, n, a, e, $time);
    end
  endtask

  // Show-ahead FIFO: head advances on each accepted pop
  always @(posedge clk50)
    for (int i = 0; i < 2; i++)
      if (flush) rp[i] <= wp[i];
      else if (pop[i] && !empty[i]) rp[i] <= rp[i] + 1;

  // Empty gating (none / toggling / random) and random watermarks
  always @(negedge clk50) begin
    for (int i = 0; i < 2; i++)
      gate[i] = (mode == 1) ? !gate[i] : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    {hw, lw} = 2'($urandom_range(0, 3));
  end

  // Monitor: writes against the scoreboard, flow control against its rule
  always @(posedge clk50) begin
    #1;
    if (mon_en)
      for (int i = 0; i < 2; i++) begin
        chk(i, "pause", pause[i], !busy[i] | hw);
        chk(i, "unpause", unpause[i], busy[i] & lw & !hw);
        chk(i, "busy_done_excl", busy[i] & done[i], 0);
        if (pop[i]) chk(i, "pop_when_empty", empty[i], 0);
        if (we[i]) begin
          if (eh[i] == et[i]) chk(i, "unexpected_write", we[i], 0);
          else begin
            chk(i, "addr", addr[i], exa[i][eh[i]]);
            chk(i, "data", din[i], exd[i][eh[i]]);
            eh[i]++;
          end
        end
      end
  end

  task automatic push(input int i, input logic [15:0] w);
    fm[i][wp[i]] = w;
    wp[i]++;
  endtask

  // Reference: the FIFO contents form a big-endian byte stream, every 3 bytes are one pixel
  task automatic expect_load(input int i);
    int n = npix(i);
    int base = rp[i];
    for (int p = 0; p < n; p++) begin
      logic [23:0] px = '0;
      for (int b = 0; b < 3; b++) begin
        int j = 3 * p + b;
        logic [15:0] w = fm[i][base + j / 2];
        px = {px[15:0], (j % 2 == 0) ? w[15:8] : w[7:0]};
      end
      exd[i][et[i]] = px;
      exa[i][et[i]] = p;
      et[i]++;
    end
    rp_end[i] = base + (3 * n + 1) / 2;
  endtask

  task automatic check_reset_values();
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_pause", pause[i], 1);
      chk(i, "rst_unpause", unpause[i], 0);
      chk(i, "rst_we", we[i], 0);
      chk(i, "rst_addr", addr[i], 0);
      chk(i, "rst_din", din[i], 0);
      chk(i, "rst_busy", busy[i], 0);
      chk(i, "rst_done", done[i], 0);
      chk(i, "rst_count", cnt[i], 0);
      chk(i, "rst_pop", pop[i], 0);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk50) start = 1'b1;
    @(posedge clk50) #1;
    for (int i = 0; i < 2; i++) begin
      chk(i, "busy_after_start", busy[i], 1);
      chk(i, "done_after_start", done[i], 0);
    end
    @(negedge clk50) start = 1'b0;
  endtask

  task automatic run_load(input bit mid_start);
    int c;
    for (int i = 0; i < 2; i++) expect_load(i);
    pulse_start();
    if (mid_start) begin
      repeat (2) @(negedge clk50);
      start = 1'b1;
      @(negedge clk50) start = 1'b0;
    end
    for (c = 0; c < 400 && !(done[0] && done[1]); c++) @(negedge clk50);
    chk(0, "load_finished", done[0] & done[1], 1);
    repeat (2) @(negedge clk50);
    for (int i = 0; i < 2; i++) begin
      chk(i, "pixel_count", cnt[i], npix(i));
      chk(i, "busy_end", busy[i], 0);
      chk(i, "done_end", done[i], 1);
      chk(i, "words_popped", rp[i], rp_end[i]);
      chk(i, "writes_outstanding", et[i] - eh[i], 0);
    end
  endtask

  initial begin
    int c, e0;
    repeat (3) @(negedge clk50);
    check_reset_values();
    mon_en = 1'b1;
    @(negedge clk50) reset = 1'b0;
    for (int i = 0; i < 2; i++)
      foreach (fm[0][k]) if (k < 6) push(i, 16'h1122 + 16'(k) * 16'h2222);
    run_load(1'b0);
    chk(1, "leftover_words", wp[1] - rp[1], 1);
    chk(1, "leftover_head", dout[1], 16'hBBCC);
    flush = 1'b1;
    @(negedge clk50) flush = 1'b0;
    mode = 1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 6; k++) push(i, 16'h1122 + 16'(k) * 16'h2222);
    run_load(1'b0);
    mode = 2;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < (3 * npix(i) + 1) / 2 + $urandom_range(0, 2); k++) push(i, 16'($urandom));
      run_load(r[0]);
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 6; k++) push(i, 16'($urandom));
    for (int i = 0; i < 2; i++) expect_load(i);
    e0 = eh[0];
    pulse_start();
    for (c = 0; c < 200 && eh[0] - e0 < 2; c++) @(negedge clk50);
    chk(0, "two_writes_before_reset", eh[0] - e0, 2);
    @(negedge clk50) reset = 1'b1;
    #1 check_reset_values();
    for (int i = 0; i < 2; i++) et[i] = eh[i];
    flush = 1'b1;
    @(negedge clk50) flush = 1'b0;
    @(negedge clk50) reset = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 6; k++) push(i, 16'($urandom));
    run_load(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
